// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, bit-timing helper and frame width.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

    function automatic int clksPerBit(input int clkFreq, input int baud);
        return clkFreq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value is selectable
// so idle-high serial lines do not look like a start bit coming out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic resetN,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled bit-centre sampling, level byteReady and stop-bit error pulse.
// Optional 2-of-3 majority bit decision when UART_RX_MAJORITY_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 27000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       uartRx,
    output logic       byteReady,
    output logic [7:0] dataOut,
    output logic       frameError
);

    localparam int CLKS_PER_BIT = clksPerBit(CLK_FREQ, BAUD);

`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ_DELAY = 1;
`else
    localparam int MAJ_DELAY = 0;
`endif

    // The majority vote needs the sample after the centre, so every decision moves one
    // cycle later; only the start check needs the shift, later bits keep CLKS_PER_BIT spacing.
    localparam logic [15:0] START_PT = 16'(CLKS_PER_BIT / 2 - 1 + MAJ_DELAY);
    localparam logic [15:0] BIT_PT   = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 8) begin : g_cpb_check
        $error("uart_rx: CLKS_PER_BIT must be at least 8");
    end

    uart_state_t state, state_next;
    logic [15:0] cnt, cnt_next;
    logic [2:0]  bit_idx, bit_idx_next;
    logic [7:0]  shift, shift_next;
    logic [7:0]  data_next;
    logic        ready_next;
    logic        ferr_next;
    logic        rx_s;
    logic        bit_val;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk    (clk),
        .resetN (resetN),
        .d      (uartRx),
        .q      (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic rx_d1, rx_d2;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rx_d1 <= 1'b1;
            rx_d2 <= 1'b1;
        end else begin
            rx_d1 <= rx_s;
            rx_d2 <= rx_d1;
        end
    end

    assign bit_val = (rx_d2 & rx_d1) | (rx_d2 & rx_s) | (rx_d1 & rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            dataOut    <= '0;
            byteReady  <= 1'b0;
            frameError <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            bit_idx    <= bit_idx_next;
            shift      <= shift_next;
            dataOut    <= data_next;
            byteReady  <= ready_next;
            frameError <= ferr_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt + 16'd1;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        data_next    = dataOut;
        ready_next   = byteReady;
        ferr_next    = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_s) state_next = START;
            end
            START: begin
                if (cnt == START_PT) begin
                    if (!bit_val) begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                        ready_next   = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == BIT_PT) begin
                    shift_next   = {bit_val, shift[7:1]};
                    bit_idx_next = bit_idx + 3'd1;
                    cnt_next     = '0;
                    if (bit_idx == LAST_BIT) state_next = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_PT) begin
                    if (bit_val) begin
                        data_next  = shift;
                        ready_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                // Wait out a held-low line so a break produces only one error pulse.
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (state_next != state) cnt_next = '0;
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames, compared each
// cycle against an event-based model of when byteReady/dataOut/frameError must change.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CLK_FREQ = 1600;
    localparam int BAUD     = 100;
    localparam int CPB      = CLK_FREQ / BAUD;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    localparam logic [7:0] GLITCH_EXP = (MAJ == 1) ? 8'hC6 : 8'h39;

    localparam int K_FALL = 0;
    localparam int K_RISE = 1;
    localparam int K_FERR = 2;

    typedef struct {
        int         t;
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       uartRx = 1'b1;
    logic       byteReady;
    logic [7:0] dataOut;
    logic       frameError;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .uartRx     (uartRx),
        .byteReady  (byteReady),
        .dataOut    (dataOut),
        .frameError (frameError)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- model state / scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    ev_t        ev_q[$];
    logic       exp_ready = 1'b0;
    logic [7:0] exp_data = 8'h00;
    bit         ready_known = 1'b1;
    bit         data_known = 1'b1;
    bit         ferr_known = 1'b1;
    bit         spur_seen = 1'b0;
    int         win_ferr = 0;
    int         ferr_total = 0;
    int         last_rise = -1;
    int         last_fall = -1;
    logic       prev_ready = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: actual %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    // Each scheduled event may land one cycle either side of its nominal time; outside
    // those windows the outputs must hold the model values exactly.
    always @(negedge clk) begin
        int kind;
        while (ev_q.size() > 0 && cyc > ev_q[0].t + 1) begin
            case (ev_q[0].kind)
                K_FALL: begin
                    exp_ready   = 1'b0;
                    ready_known = 1'b1;
                    ferr_known  = 1'b1;
                end
                K_RISE: begin
                    exp_ready   = 1'b1;
                    exp_data    = ev_q[0].data;
                    ready_known = 1'b1;
                    data_known  = 1'b1;
                end
                default: begin
                    check("frame_error_pulse_count", win_ferr, 1);
                    win_ferr = 0;
                end
            endcase
            void'(ev_q.pop_front());
        end
        kind = (ev_q.size() > 0 && cyc >= ev_q[0].t - 1) ? ev_q[0].kind : -1;

        if (frameError) ferr_total++;
        if (ferr_known) begin
            if (kind == K_FERR) begin
                if (frameError) win_ferr++;
            end else begin
                check("frame_error_quiet", int'(frameError), 0);
            end
        end else if (frameError || byteReady) begin
            spur_seen = 1'b1;
        end
        if (ready_known && kind != K_FALL && kind != K_RISE)
            check("byte_ready", int'(byteReady), int'(exp_ready));
        if (data_known && kind != K_RISE)
            check("data_out", int'(dataOut), int'(exp_data));

        if (byteReady && !prev_ready) last_rise = cyc;
        if (!byteReady && prev_ready) last_fall = cyc;
        prev_ready = byteReady;
    end

    // ---------------- driver tasks ----------------
    task automatic line(input logic v, input int n);
        uartRx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_ev(input int t, input int kind, input logic [7:0] data);
        ev_t ev;
        ev.t    = t;
        ev.kind = kind;
        ev.data = data;
        ev_q.push_back(ev);
    endtask

    // Nominal timing: start confirmed 2 + CPB/2 cycles after the falling edge, stop bit
    // judged 9*CPB later. A centre glitch flips every bit unless majority voting is on.
    task automatic send_frame(input logic [7:0] d, input logic stop, input bit glitch, output int e);
        logic [7:0] seen;
        e = cyc;
        seen = (glitch && MAJ == 0) ? ~d : d;
        push_ev(e + 2 + CPB / 2 + MAJ, K_FALL, 8'h00);
        push_ev(e + 2 + CPB / 2 + 9 * CPB + MAJ, stop ? K_RISE : K_FERR, seen);
        line(1'b0, CPB);
        for (int i = 0; i < 8; i++) begin
            if (glitch) begin
                line(d[i], CPB / 2);
                line(~d[i], 1);
                line(d[i], CPB / 2 - 1);
            end else begin
                line(d[i], CPB);
            end
        end
        line(stop, CPB);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         e;
        int         e2;
        int         f0;
        int         r;
        int         n;
        logic [7:0] d;
        logic [7:0] rd;

        resetN = 1'b0;
        uartRx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_byte_ready", int'(byteReady), 0);
        check("reset_data_out", int'(dataOut), 8'h00);
        check("reset_frame_error", int'(frameError), 0);
        resetN = 1'b1;
        line(1'b1, 20);

        // Ideal 0x55 frame and its latency.
        send_frame(8'h55, 1'b1, 1'b0, e);
        line(1'b1, 4);
        check("first_byte", int'(dataOut), 8'h55);
        check("first_ready", int'(byteReady), 1);
        check_range("byte_ready_latency", last_rise - e, 153 + MAJ, 155 + MAJ);

        // Back-to-back frames with no idle gap.
        send_frame(8'hA3, 1'b1, 1'b0, e);
        send_frame(8'h0F, 1'b1, 1'b0, e2);
        line(1'b1, 10);
        check_range("ready_drop_at_second_start", last_fall - e2, 9 + MAJ, 11 + MAJ);
        check("b2b_byte", int'(dataOut), 8'h0F);
        check("b2b_ready", int'(byteReady), 1);

        // Short low pulse on an idle line is rejected.
        line(1'b1, 20);
        line(1'b0, 5);
        line(1'b1, 30);
        check("glitch_keeps_byte", int'(dataOut), 8'h0F);
        check("glitch_keeps_ready", int'(byteReady), 1);

        // Bad stop bit followed by a held-low break.
        f0 = ferr_total;
        send_frame(8'h3C, 1'b0, 1'b0, e);
        line(1'b0, 40);
        line(1'b1, 20);
        check("break_single_ferr", ferr_total - f0, 1);
        check("break_keeps_byte", int'(dataOut), 8'h0F);
        check("break_ready_cleared_by_start", int'(byteReady), 0);
        send_frame(8'h81, 1'b1, 1'b0, e);
        line(1'b1, 20);
        check("after_break_byte", int'(dataOut), 8'h81);

        // Reset pulse during data bit 4 of 0x25, released while the line is still low.
        d = 8'h25;
        e = cyc;
        push_ev(e + 2 + CPB / 2 + MAJ, K_FALL, 8'h00);
        line(1'b0, CPB);
        for (int i = 0; i < 4; i++) line(d[i], CPB);
        line(d[4], 4);
        resetN = 1'b0;
        ev_q.delete();
        exp_ready   = 1'b0;
        exp_data    = 8'h00;
        ready_known = 1'b1;
        data_known  = 1'b1;
        ferr_known  = 1'b1;
        win_ferr    = 0;
        #1;
        check("midframe_reset_ready", int'(byteReady), 0);
        check("midframe_reset_data", int'(dataOut), 8'h00);
        check("midframe_reset_ferr", int'(frameError), 0);
        @(posedge clk);
        #1;
        resetN      = 1'b1;
        ready_known = 1'b0;
        data_known  = 1'b0;
        ferr_known  = 1'b0;
        spur_seen   = 1'b0;
        line(d[4], CPB - 5);
        for (int i = 5; i < 8; i++) line(d[i], CPB);
        line(1'b1, 20 * CPB);
        check("spurious_frame_terminates", int'(spur_seen), 1);
        send_frame(8'h5A, 1'b1, 1'b0, e);
        line(1'b1, 20);
        check("after_reset_byte", int'(dataOut), 8'h5A);
        check("after_reset_ready", int'(byteReady), 1);

        // Single-cycle inverted glitch at the centre of each data bit.
        send_frame(8'hC6, 1'b1, 1'b1, e);
        line(1'b1, 20);
        check("centre_glitch_byte", int'(dataOut), int'(GLITCH_EXP));

        // Random traffic: good frames, bad stops with breaks, idle glitches, random gaps.
        for (int k = 0; k < 16; k++) begin
            rd = 8'($urandom_range(0, 255));
            r  = $urandom_range(0, 9);
            if (r < 2) begin
                n = $urandom_range(1, 6);
                line(1'b0, n);
                line(1'b1, CPB + 4);
            end
            if (r >= 7) begin
                send_frame(rd, 1'b0, 1'b0, e);
                line(1'b0, $urandom_range(0, 30));
                line(1'b1, $urandom_range(4, 20));
            end else begin
                send_frame(rd, 1'b1, 1'b0, e);
                n = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20);
                line(1'b1, n);
            end
        end

        line(1'b1, 40);
        check("events_drained", ev_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
